// File: rtl/dct_block_zigzag_serializer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dct_block_zigzag_serializer
//
// Purpose:
//   Accepts one 8x8 block of Y/Cb/Cr DCT coefficients in a single valid/ready
//   transfer. It then streams the block out one coefficient triplet per beat,
//   in JPEG zigzag order. The stream feeds the quantizer/entropy coder.
//   Coefficient words pass through bit-exact.
//
// Build option:
//   DCT_SERIALIZER_DOUBLE_BUF_EN
//     Undefined (default):
//       - One bank with an IDLE/STREAM FSM.
//       - A new block is accepted the cycle after the last beat of the
//         previous block, so a block takes 65 cycles.
//     Defined:
//       - Two ping-pong banks, each with a full flag.
//       - A block can be captured while the other bank streams.
//       - Back-to-back blocks stream without a bubble, so a block takes
//         64 cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   block-level input valid
//   in_ready   block-level input ready
//   dct_y_in   64 Y coefficients, raster index i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dct_cb_in  64 Cb coefficients, same packing
//   dct_cr_in  64 Cr coefficients, same packing
//   out_valid  stream beat valid
//   out_ready  stream beat ready
//   out_y      Y coefficient at raster position out_pos
//   out_cb     Cb coefficient at raster position out_pos
//   out_cr     Cr coefficient at raster position out_pos
//   out_idx    zigzag scan index k (0..63)
//   out_pos    raster position zz(k)
//   out_last   high on the k=63 beat
//   out_blk    sequence number of the block being streamed
// -----------------------------------------------------------------------------
module dct_block_zigzag_serializer #(
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = 15,
  parameter int BLK_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [64*DATA_WIDTH-1:0]  dct_y_in,
  input  logic [64*DATA_WIDTH-1:0]  dct_cb_in,
  input  logic [64*DATA_WIDTH-1:0]  dct_cr_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_y,
  output logic [DATA_WIDTH-1:0]     out_cb,
  output logic [DATA_WIDTH-1:0]     out_cr,
  output logic [5:0]                out_idx,
  output logic [5:0]                out_pos,
  output logic                      out_last,
  output logic [BLK_CNT_WIDTH-1:0]  out_blk
);

  // The fraction position only describes the words; reject a format that
  // cannot exist so a bad parameterisation is caught at elaboration.
  if (FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_BITS must lie in [0, DATA_WIDTH-1]");
  end

  localparam logic [5:0] LAST_K = 6'd63;

  // Standard JPEG zigzag scan: scan index k -> raster index row*8+col.
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic [5:0]               r_k;
  logic [BLK_CNT_WIDTH-1:0] r_blk;
  logic [5:0]               w_pos;
  logic                     w_xfer;
  logic                     w_end;
  logic                     w_cap;

  assign w_pos  = 6'(ZZ[r_k]);
  assign w_xfer = out_valid & out_ready;
  assign w_end  = w_xfer & (r_k == LAST_K);
  assign w_cap  = in_valid & in_ready;

  // Scan index and block counter. The block counter wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k   <= 6'd0;
      r_blk <= '0;
    end else if (w_end) begin
      r_k   <= 6'd0;
      r_blk <= r_blk + BLK_CNT_WIDTH'(1);
    end else if (w_xfer) begin
      r_k   <= r_k + 6'd1;
    end
  end

  assign out_idx  = r_k;
  assign out_pos  = w_pos;
  assign out_last = out_valid & (r_k == LAST_K);
  assign out_blk  = r_blk;

`ifdef DCT_SERIALIZER_DOUBLE_BUF_EN

  // ---------------- ping-pong banks ----------------
  logic [DATA_WIDTH-1:0] r_y_bank  [2][64];
  logic [DATA_WIDTH-1:0] r_cb_bank [2][64];
  logic [DATA_WIDTH-1:0] r_cr_bank [2][64];
  logic [1:0]            r_full;
  logic                  r_rd;
  logic [1:0]            w_full_nxt;
  logic                  w_wr;

  // The read pointer always designates a full bank whenever any bank is
  // full, and rests on bank 0 when both are empty. Capture therefore goes to
  // the other bank when streaming, and to bank 0 otherwise.
  assign w_wr      = r_full[r_rd] ? ~r_rd : r_rd;
  assign in_ready  = ~rst & ~(&r_full);
  assign out_valid = r_full[r_rd];

  always_comb begin
    w_full_nxt = r_full;
    if (w_end) w_full_nxt[r_rd] = 1'b0;
    if (w_cap) w_full_nxt[w_wr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
      r_rd   <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      // On the last beat, hop to the other bank if it holds a block
      // (including one captured this very cycle); otherwise park on bank 0.
      if (w_end) r_rd <= w_full_nxt[~r_rd] ? ~r_rd : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) begin
      for (int i = 0; i < 64; i++) begin
        r_y_bank[w_wr][i]  <= dct_y_in[i*DATA_WIDTH +: DATA_WIDTH];
        r_cb_bank[w_wr][i] <= dct_cb_in[i*DATA_WIDTH +: DATA_WIDTH];
        r_cr_bank[w_wr][i] <= dct_cr_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_y  = r_y_bank[r_rd][w_pos];
  assign out_cb = r_cb_bank[r_rd][w_pos];
  assign out_cr = r_cr_bank[r_rd][w_pos];

`else

  // ---------------- single bank with IDLE/STREAM control ----------------
  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_y_bank  [64];
  logic [DATA_WIDTH-1:0] r_cb_bank [64];
  logic [DATA_WIDTH-1:0] r_cr_bank [64];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        if (out_ready && (r_k == LAST_K)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_cap) begin
      for (int i = 0; i < 64; i++) begin
        r_y_bank[i]  <= dct_y_in[i*DATA_WIDTH +: DATA_WIDTH];
        r_cb_bank[i] <= dct_cb_in[i*DATA_WIDTH +: DATA_WIDTH];
        r_cr_bank[i] <= dct_cr_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign out_y  = r_y_bank[w_pos];
  assign out_cb = r_cb_bank[w_pos];
  assign out_cr = r_cr_bank[w_pos];

`endif

endmodule

// File: doc/dct_block_zigzag_serializer.md
Name: dct_block_zigzag_serializer

Overview:
- Consumer end of the block-level DCT output handshake.
- Accepts one full 8x8 block of Y, Cb and Cr DCT coefficients as three 64-word parallel buses in a single valid/ready transfer.
- Buffers the block and streams it out one coefficient triplet per beat, in JPEG zigzag order, on a valid/ready stream.
- Sits between the combined RGB→YCbCr+DCT stage and the downstream quantizer/entropy coder.

Parameters:
- DATA_WIDTH, 32: width of one fixed-point coefficient word.
- FRAC_BITS, 15: fraction bits of coefficient words. Pass-through only; no arithmetic uses it.
- BLK_CNT_WIDTH, 16: width of the output block counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  block-level input valid.
- in_ready  output  1  block-level input ready.
- dct_y_in  input  64*DATA_WIDTH  Y coefficients; raster index i=row*8+col occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- dct_cb_in  input  64*DATA_WIDTH  Cb coefficients; same packing.
- dct_cr_in  input  64*DATA_WIDTH  Cr coefficients; same packing.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  stream beat ready.
- out_y  output  DATA_WIDTH  Y coefficient at raster position out_pos.
- out_cb  output  DATA_WIDTH  Cb coefficient at raster position out_pos.
- out_cr  output  DATA_WIDTH  Cr coefficient at raster position out_pos.
- out_idx  output  6  zigzag scan index k, 0..63.
- out_pos  output  6  raster position zz(k).
- out_last  output  1  high only on the beat with k=63.
- out_blk  output  BLK_CNT_WIDTH  sequence number of the block being streamed.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - out_valid=0, out_last=0, out_idx=0, out_blk=0; buffers marked empty; state IDLE.
  - in_ready=0 while rst=1.
  - out_y/out_cb/out_cr/out_pos are don't-care while out_valid=0.
- States (single-buffer build):
  - IDLE: in_ready=1.
  - STREAM: in_ready=0.
- Capture:
  - In IDLE, in_valid&&in_ready at a rising edge latches all three 64-word buses into the bank and moves to STREAM.
  - out_valid=1 from the next cycle, with k=0.
- Stream:
  - out_* is driven from the bank through a mux indexed by the registered k.
  - out_pos=zz(k) from a 64-entry constant ROM, standard JPEG zigzag: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
  - A beat transfers on out_valid&&out_ready; k then increments.
  - With out_ready=0, every out_* signal holds stable. out_valid never drops without a transfer.
- End of block:
  - The transfer with k=63 (out_last=1) returns to IDLE and increments out_blk; the counter wraps modulo 2^BLK_CNT_WIDTH.
  - in_ready=1 the following cycle.
  - Minimum period is 65 cycles per block.
- Bit-exact: coefficient words pass through unchanged, with no rounding, sign extension or saturation.
- in_valid while in_ready=0: ignored. Input buses may change freely; the buffer is untouched.
- Mid-operation reset: the current block is discarded. out_valid=0 and in_ready=0 on the cycle after the rst edge; in_ready=1 on the first cycle after rst deasserts. The next accepted block starts at k=0 with out_blk=0.

Optional Feature:
- Macro: DCT_SERIALIZER_DOUBLE_BUF_EN.
- Defined: two ping-pong banks, each with a full flag.
  - in_ready=~rst && (at least one bank empty).
  - Capture goes to the empty bank; when both are empty, bank 0.
  - The bank being streamed is freed on its k=63 transfer. If the other bank is full, the next cycle presents k=0 of that bank with out_valid held at 1, so there is no bubble.
  - A capture and a k=63 transfer in the same cycle are both honoured.
  - Sustained throughput is 64 cycles per block.
- Undefined: single bank and the IDLE/STREAM behaviour above.

Test Plan:
- Single block, Y[i]=i, Cb[i]=0x100+i, Cr[i]=0x200+i, out_ready=1:
  - 64 beats with out_pos sequence 0,1,8,16,9,2,...,63.
  - On every beat out_y=out_pos, out_cb=0x100+out_pos, out_cr=0x200+out_pos, out_idx=0..63.
  - out_last only on beat 63; out_blk=0.
- Backpressure with out_ready pattern 1,0,0,1 repeating:
  - Exactly 64 transfers, no duplicates or skips.
  - Outputs stable throughout every stall.
  - out_valid never deasserts mid-block.
- Busy input:
  - Second block offered with in_valid=1 during beat 10: in_ready=0 and the first block streams unchanged.
  - The second block is accepted the cycle after beat 63.
  - out_blk=1 on its beats; the first accept-to-accept gap is 65 cycles.
- Double buffer (DCT_SERIALIZER_DOUBLE_BUF_EN defined), 4 blocks back-to-back with out_ready=1:
  - Continuous out_valid.
  - 256 beats in 256 consecutive cycles after the first beat.
  - out_blk runs 0..3.
- Reset mid-block, rst=1 for 2 cycles at beat 20:
  - out_valid=0 and in_ready=0 on the cycle after the rst edge.
  - in_ready=1 on the first cycle after release.
  - The next block streams from k=0 with out_blk=0.
- Wrap, with BLK_CNT_WIDTH=2: 5 blocks give out_blk sequence 0,1,2,3,0.
